// File: rtl/alu_sched_pkg.sv
// Shared state encoding, opcode classes and helpers for the ALU operation scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_MUL_LO = 5'b00010;
  localparam logic [4:0] OP_MUL_HI = 5'b00101;
  localparam logic [4:0] OP_DIV_LO = 5'b00110;
  localparam logic [4:0] OP_DIV_HI = 5'b01001;

  localparam logic [31:0] TIMEOUT_RESULT = 32'hDEAD_BEEF;

  function automatic logic is_multicycle(input logic [4:0] opcode);
    return ((opcode >= OP_MUL_LO) && (opcode <= OP_MUL_HI)) ||
           ((opcode >= OP_DIV_LO) && (opcode <= OP_DIV_HI));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves to the non-granted side on advance.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       adv_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_valid = |req;
    if (req[0] && req[1]) begin
      gnt_id = ptr_q;
    end else begin
      gnt_id = req[1];
    end
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = ~adv_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Two-requester front end for the shared ALU: arbitrate, hold operands, wait, respond.
// Optional watchdog in WAIT enabled by defining ALU_TIMEOUT_EN.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [4:0]  req0_opcode,
  output logic        rsp0_valid,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [4:0]  req1_opcode,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [31:0] alu_operator_1,
  output logic [31:0] alu_operator_2,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_answer,
  input  logic        alu_complete,
  output logic        busy
);

  if ((SETTLE_CYCLES < 1) || ((2 ** CNT_W) < SETTLE_CYCLES) ||
      ((2 ** CNT_W) < TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too narrow for SETTLE_CYCLES/TIMEOUT_CYCLES");
  end

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        gid_q, gid_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [4:0]  opc_q, opc_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic        busy_q, busy_d;
  logic        gnt_valid, gnt_id, advance;

`ifdef ALU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  logic        to_q, to_d;
  logic        rsp_err_q, rsp_err_d;
`endif

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1_valid, req0_valid}),
    .advance   (advance),
    .adv_id    (gid_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Ready is a same-cycle acknowledge of the IDLE grant; the grant itself is registered.
  assign req0_ready = (state_q == IDLE) && !rst && gnt_valid && !gnt_id;
  assign req1_ready = (state_q == IDLE) && !rst && gnt_valid && gnt_id;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gid_d        = gid_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    opc_d        = opc_q;
    rsp_result_d = rsp_result_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    busy_d       = busy_q;
    advance      = 1'b0;
`ifdef ALU_TIMEOUT_EN
    to_d         = to_q;
    rsp_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
          gid_d   = gnt_id;
          busy_d  = 1'b1;
          op1_d   = gnt_id ? req1_op1 : req0_op1;
          op2_d   = gnt_id ? req1_op2 : req0_op2;
          opc_d   = gnt_id ? req1_opcode : req0_opcode;
`ifdef ALU_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          if (is_multicycle(opc_q)) begin
            state_d = WAIT;
`ifdef ALU_TIMEOUT_EN
            cnt_d   = TIMEOUT_LOAD;
`endif
          end else begin
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // alu_complete is only trusted here; during SETTLE it may still be high from the last op.
      WAIT: begin
        if (alu_complete) begin
          state_d = RESP;
        end
`ifdef ALU_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = RESP;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      RESP: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        advance      = 1'b1;
        rsp0_valid_d = ~gid_q;
        rsp1_valid_d = gid_q;
`ifdef ALU_TIMEOUT_EN
        rsp_result_d = to_q ? TIMEOUT_RESULT : alu_answer;
        rsp_err_d    = to_q;
`else
        rsp_result_d = alu_answer;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gid_q        <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      opc_q        <= OP_ADD;
      rsp_result_q <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      to_q         <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gid_q        <= gid_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      opc_q        <= opc_d;
      rsp_result_q <= rsp_result_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
`ifdef ALU_TIMEOUT_EN
      to_q         <= to_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign alu_operator_1 = op1_q;
  assign alu_operator_2 = op2_q;
  assign alu_opcode     = opc_q;
  assign rsp_result     = rsp_result_q;
  assign rsp0_valid     = rsp0_valid_q;
  assign rsp1_valid     = rsp1_valid_q;
  assign busy           = busy_q;
`ifdef ALU_TIMEOUT_EN
  assign rsp_err        = rsp_err_q;
`else
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: directed table, corner sequences, random traffic.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  localparam int S   = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [4:0]  req0_opcode = '0, req1_opcode = '0;
  logic [31:0] rsp_result, alu_operator_1, alu_operator_2, alu_answer;
  logic [4:0]  alu_opcode;
  logic        alu_complete = 1'b1;

  always #5 clk = ~clk;

  alu_op_scheduler #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TMO), .CNT_W(9)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_opcode(req0_opcode), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_opcode(req1_opcode), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_operator_1(alu_operator_1), .alu_operator_2(alu_operator_2),
    .alu_opcode(alu_opcode), .alu_answer(alu_answer),
    .alu_complete(alu_complete), .busy(busy)
  );

  // Behavioural ALU: add, low-word multiply, unsigned divide (all ones on /0), xor otherwise.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    if (op == 5'd0) return a + b;
    if (op >= 5'd2 && op <= 5'd5) return a * b;
    if (op >= 5'd6 && op <= 5'd9) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    return a ^ b;
  endfunction

  assign alu_answer = ref_alu(alu_operator_1, alu_operator_2, alu_opcode);

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit inflight = 0, gid = 0, mul = 0, ptr = 0, granted = 0, got_rsp = 0, e_err = 0;
  int issue_t = 0, rsp_cyc = 0, lo_len = 2, next_lo_len = 2, lat_last = 0, n_rsp = 0;
  logic [31:0] e_res, e_op1, e_op2;
  logic [4:0]  e_opc;
  int grant_log[$];

  typedef struct {
    bit          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opc;
    int          lo;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Complete profile of a multi-cycle op issued at t: stale high up to t+2,
  // low for lo_len cycles, then high.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (inflight && mul)
      alu_complete = (cyc <= issue_t + 2) || (cyc >= issue_t + 3 + lo_len);
    else
      alu_complete = 1'b1;
  endtask

  task automatic run_cycle();
    bit g_ok, g_id;
    #1;
    granted = 0;
    got_rsp = 0;
    if (inflight && cyc == rsp_cyc) begin
      chk("rsp0_valid", rsp0_valid, !gid);
      chk("rsp1_valid", rsp1_valid, gid);
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_err", rsp_err, e_err);
      inflight = 0;
      ptr = !gid;
      got_rsp = 1;
      lat_last = cyc - issue_t;
      n_rsp++;
    end else begin
      chk("rsp0_quiet", rsp0_valid, 0);
      chk("rsp1_quiet", rsp1_valid, 0);
    end
    chk("busy", busy, inflight);
    g_ok = !inflight && (req0_valid || req1_valid);
    g_id = (req0_valid && req1_valid) ? ptr : req1_valid;
    chk("req0_ready", req0_ready, g_ok && !g_id);
    chk("req1_ready", req1_ready, g_ok && g_id);
    if (inflight) begin
      chk("alu_operator_1", alu_operator_1, e_op1);
      chk("alu_operator_2", alu_operator_2, e_op2);
      chk("alu_opcode", alu_opcode, e_opc);
    end
    if (g_ok) begin
      inflight = 1;
      granted  = 1;
      gid      = g_id;
      issue_t  = cyc;
      e_op1    = g_id ? req1_op1 : req0_op1;
      e_op2    = g_id ? req1_op2 : req0_op2;
      e_opc    = g_id ? req1_opcode : req0_opcode;
      mul      = (e_opc >= 5'd2) && (e_opc <= 5'd9);
      e_res    = ref_alu(e_op1, e_op2, e_opc);
      e_err    = 0;
      lo_len   = next_lo_len;
      rsp_cyc  = mul ? issue_t + 5 + lo_len : issue_t + S + 2;
`ifdef ALU_TIMEOUT_EN
      if (mul && (3 + lo_len > S + TMO)) begin
        rsp_cyc = issue_t + S + TMO + 2;
        e_res   = 32'hDEAD_BEEF;
        e_err   = 1;
      end
`endif
      grant_log.push_back(int'(g_id));
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst = 1'b0;
    inflight = 0;
    ptr = 0;
    granted = 0;
    got_rsp = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_operator_1", alu_operator_1, 0);
    chk("rst_alu_operator_2", alu_operator_2, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
  endtask

  task automatic drive(input bit rq, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] o);
    if (rq) begin
      req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_opcode = o;
    end else begin
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_opcode = o;
    end
  endtask

  task automatic do_op(input bit rq, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] o, input int lo, input logic [31:0] res,
                       input int lat);
    bit done, prev;
    done = 0;
    prev = 0;
    next_lo_len = lo;
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      if (c == 0) drive(rq, a, b, o);
      else if (prev) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      run_cycle();
      prev = granted;
      if (got_rsp) begin
        done = 1;
        chk("op_result", rsp_result, res);
        chk("op_latency", lat_last, lat);
      end
    end
    chk("op_completed", done, 1);
  endtask

  task automatic rand_op(output logic [31:0] a, output logic [31:0] b, output logic [4:0] o);
    a = $urandom;
    b = $urandom;
    if ($urandom_range(0, 1) == 1) o = 5'($urandom_range(2, 9));
    else o = 5'($urandom_range(0, 31));
    if (o >= OP_DIV_LO && o <= OP_DIV_HI && $urandom_range(0, 3) == 0)
      b = 32'($urandom_range(0, 3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int base, left0, left1;
    bit pend0, pend1;
    tbl[0] = '{1'b0, 32'd5,          32'd7,       OP_ADD,    2,  32'd12,       S + 2};
    tbl[1] = '{1'b1, 32'd6,          32'd7,       OP_MUL_LO, 10, 32'd42,       15};
    tbl[2] = '{1'b0, 32'd100,        32'd7,       OP_DIV_LO, 2,  32'd14,       7};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF,  32'd1,       OP_ADD,    2,  32'd0,        S + 2};
    tbl[4] = '{1'b1, 32'd9,          32'd0,       OP_DIV_HI, 4,  32'hFFFF_FFFF, 9};
    tbl[5] = '{1'b0, 32'd3,          32'd5,       5'b01010,  2,  32'd6,        S + 2};
    tbl[6] = '{1'b0, 32'd3,          32'd5,       5'b00001,  2,  32'd6,        S + 2};
    tbl[7] = '{1'b1, 32'h0001_0000,  32'h0001_0000, OP_MUL_HI, 3, 32'd0,       8};

    do_reset();

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].rq, tbl[i].a, tbl[i].b, tbl[i].opc, tbl[i].lo, tbl[i].res, tbl[i].lat);

`ifdef ALU_TIMEOUT_EN
    do_op(1'b0, 32'd6, 32'd7, OP_MUL_LO, 1000, 32'hDEAD_BEEF, S + TMO + 2);
    do_op(1'b0, 32'd6, 32'd7, OP_MUL_LO, 2, 32'd42, 7);
    do_op(1'b1, 32'd6, 32'd7, OP_MUL_LO, 17, 32'd42, S + TMO + 2);
`endif

    // Reset while a divide sits in WAIT: the op is abandoned and never answered.
    next_lo_len = 12;
    step(); drive(1'b0, 32'd100, 32'd5, OP_DIV_LO); run_cycle();
    chk("midrst_granted", granted, 1);
    step(); req0_valid = 1'b0; run_cycle();
    for (int i = 0; i < 6; i++) begin step(); run_cycle(); end
    do_reset();
    for (int i = 0; i < 15; i++) begin step(); run_cycle(); end
    do_op(1'b0, 32'd20, 32'd22, OP_ADD, 2, 32'd42, S + 2);

    // Contention: both requesters hold valid for four ops each.
    do_reset();
    grant_log.delete();
    base = n_rsp;
    left0 = 4;
    left1 = 4;
    rand_op(req0_op1, req0_op2, req0_opcode);
    rand_op(req1_op1, req1_op2, req1_opcode);
    for (int c = 0; c < 400 && (n_rsp - base) < 8; c++) begin
      step();
      if (c == 0) begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
      end else if (granted) begin
        if (gid) begin
          left1--;
          if (left1 > 0) rand_op(req1_op1, req1_op2, req1_opcode);
          else req1_valid = 1'b0;
        end else begin
          left0--;
          if (left0 > 0) rand_op(req0_op1, req0_op2, req0_opcode);
          else req0_valid = 1'b0;
        end
      end
      next_lo_len = $urandom_range(2, 6);
      run_cycle();
    end
    chk("cont_rsp_count", n_rsp - base, 8);
    for (int i = 0; i < 8; i++)
      chk("cont_grant_order", (i < grant_log.size()) ? grant_log[i] : 2, i % 2);

    // Random traffic against the reference model.
    do_reset();
    pend0 = 0;
    pend1 = 0;
    for (int c = 0; c < 2500; c++) begin
      step();
      if (granted) begin
        if (gid) pend1 = 0;
        else pend0 = 0;
      end
      if (!pend0 && $urandom_range(0, 3) == 0) begin
        pend0 = 1;
        rand_op(req0_op1, req0_op2, req0_opcode);
      end
      if (!pend1 && $urandom_range(0, 3) == 0) begin
        pend1 = 1;
        rand_op(req1_op1, req1_op2, req1_opcode);
      end
      req0_valid = pend0 && ($urandom_range(0, 4) != 0);
      req1_valid = pend1 && ($urandom_range(0, 4) != 0);
      next_lo_len = $urandom_range(2, 12);
      run_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      run_cycle();
    end
    chk("drain_idle", inflight, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
